// File: rtl/pc_sequencer.sv
// Fetch program counter for the 5-stage MIPS pipeline: branch/jump resolution from ID,
// stall hold and a latched exception redirect. Define PC_SEQ_PERF_EN to build the perf counters.
module pc_sequencer #(
    parameter logic [31:0] RESET_PC   = 32'h0000_3000,
    parameter logic [31:0] EXC_VECTOR = 32'h0000_4180,
    parameter int          CNT_W      = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall,
    input  logic             id_valid,
    input  logic [3:0]       id_op,
    input  logic [31:0]      id_pc4,
    input  logic [31:0]      id_rs_val,
    input  logic [31:0]      id_rt_val,
    input  logic [15:0]      id_imm16,
    input  logic [25:0]      id_index,
    input  logic             exc_req,
    output logic [31:0]      pc,
    output logic [31:0]      pc4,
    output logic             redirect,
    output logic             addr_err,
    output logic             exc_pending,
    output logic [CNT_W-1:0] cnt_taken,
    output logic [CNT_W-1:0] cnt_jump,
    output logic [CNT_W-1:0] cnt_stall
);

    typedef enum logic {RUN, EXC_PEND} state_t;

    state_t      state_reg;
    logic [31:0] pc_reg;
    logic        redirect_reg;
    logic        addr_err_reg;
    logic        exc_pending_reg;

    logic [3:0]  op_eff;
    logic [31:0] br_target;
    logic [31:0] j_target;
    logic        cond_taken;
    logic        is_jump;
    logic        id_misalign;
    logic        id_redirect;
    logic [31:0] id_target;
    logic        exc_fire;
    logic        accept;

    assign pc4       = pc_reg + 32'd4;
    assign op_eff    = id_valid ? id_op : 4'd0;
    assign br_target = id_pc4 + {{14{id_imm16[15]}}, id_imm16, 2'b00};
    assign j_target  = {id_pc4[31:28], id_index, 2'b00};

    always_comb begin
        cond_taken  = 1'b0;
        is_jump     = 1'b0;
        id_misalign = 1'b0;
        unique case (op_eff)
            4'd1: cond_taken = (id_rs_val == id_rt_val);
            4'd2: cond_taken = (id_rs_val != id_rt_val);
            4'd3: cond_taken = ~id_rs_val[31];
            4'd4: cond_taken = id_rs_val[31];
            4'd5: cond_taken = id_rs_val[31] || (id_rs_val == 32'd0);
            4'd6: cond_taken = ~id_rs_val[31] && (id_rs_val != 32'd0);
            4'd7: is_jump    = 1'b1;
            4'd8: begin
                is_jump     = 1'b1;
                id_misalign = (id_rs_val[1:0] != 2'b00);
            end
            default: ;
        endcase
    end

    always_comb begin
        id_target = pc4;
        if (cond_taken)
            id_target = br_target;
        else if (op_eff == 4'd7)
            id_target = j_target;
        else if (op_eff == 4'd8)
            id_target = id_misalign ? EXC_VECTOR : id_rs_val;
    end

    assign id_redirect = cond_taken | is_jump;
    // An exception (fresh or latched) is applied only on a non-stalled cycle.
    assign exc_fire    = ((state_reg == EXC_PEND) || exc_req) && !stall;
    assign accept      = !stall && !exc_fire;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg       <= RUN;
            pc_reg          <= RESET_PC;
            redirect_reg    <= 1'b0;
            addr_err_reg    <= 1'b0;
            exc_pending_reg <= 1'b0;
        end else begin
            redirect_reg <= 1'b0;
            addr_err_reg <= 1'b0;
            unique case (state_reg)
                RUN: begin
                    if (exc_req && stall) begin
                        state_reg       <= EXC_PEND;
                        exc_pending_reg <= 1'b1;
                    end else if (exc_req) begin
                        pc_reg       <= EXC_VECTOR;
                        redirect_reg <= 1'b1;
                    end else if (!stall) begin
                        pc_reg       <= id_target;
                        redirect_reg <= id_redirect;
                        addr_err_reg <= id_misalign;
                    end
                end
                EXC_PEND: begin
                    // Extra exc_req pulses while stalled here are absorbed.
                    if (!stall) begin
                        state_reg       <= RUN;
                        exc_pending_reg <= 1'b0;
                        pc_reg          <= EXC_VECTOR;
                        redirect_reg    <= 1'b1;
                    end
                end
                default: state_reg <= RUN;
            endcase
        end
    end

    assign pc          = pc_reg;
    assign redirect    = redirect_reg;
    assign addr_err    = addr_err_reg;
    assign exc_pending = exc_pending_reg;

`ifdef PC_SEQ_PERF_EN
    logic [2:0]       cnt_inc;
    logic [CNT_W-1:0] cnt_reg [3];

    assign cnt_inc = {stall, accept && is_jump, accept && cond_taken};

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_cnt
            always_ff @(posedge clk or posedge reset) begin
                if (reset)
                    cnt_reg[gi] <= '0;
                else if (cnt_inc[gi])
                    cnt_reg[gi] <= cnt_reg[gi] + CNT_W'(1);
            end
        end
    endgenerate

    assign cnt_taken = cnt_reg[0];
    assign cnt_jump  = cnt_reg[1];
    assign cnt_stall = cnt_reg[2];
`else
    assign cnt_taken = '0;
    assign cnt_jump  = '0;
    assign cnt_stall = '0;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed scoreboard bench for pc_sequencer: the driver queues hand-computed expectations,
// the monitor pops and compares after each clock edge (or an asynchronous-reset check event).
module tb_pc_sequencer;

`ifdef PC_SEQ_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        stall = 1'b0;
    logic        id_valid = 1'b0;
    logic [3:0]  id_op = 4'd0;
    logic [31:0] id_pc4 = 32'd0;
    logic [31:0] id_rs_val = 32'd0;
    logic [31:0] id_rt_val = 32'd0;
    logic [15:0] id_imm16 = 16'd0;
    logic [25:0] id_index = 26'd0;
    logic        exc_req = 1'b0;
    logic [31:0] pc, pc4;
    logic        redirect, addr_err, exc_pending;
    logic [7:0]  cnt_taken, cnt_jump, cnt_stall;

    pc_sequencer #(.CNT_W(8)) dut (
        .clk(clk), .reset(reset), .stall(stall), .id_valid(id_valid), .id_op(id_op),
        .id_pc4(id_pc4), .id_rs_val(id_rs_val), .id_rt_val(id_rt_val), .id_imm16(id_imm16),
        .id_index(id_index), .exc_req(exc_req), .pc(pc), .pc4(pc4), .redirect(redirect),
        .addr_err(addr_err), .exc_pending(exc_pending), .cnt_taken(cnt_taken),
        .cnt_jump(cnt_jump), .cnt_stall(cnt_stall)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [31:0] pc;
        logic        redir;
        logic        aerr;
        logic        pend;
        bit          chk_cnt;
        logic [7:0]  tk;
        logic [7:0]  jp;
        logic [7:0]  st;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad = 0;
    bit   drv_done = 1'b0;
    event chk_ev;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: compares against the oldest queued expectation.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk or chk_ev);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                $display("txn %-10s pc=%h redir=%0b aerr=%0b pend=%0b cnt=%0d/%0d/%0d",
                         e.name, pc, redirect, addr_err, exc_pending, cnt_taken, cnt_jump, cnt_stall);
                chk({e.name, ".pc"}, pc, e.pc);
                chk({e.name, ".pc4"}, pc4, e.pc + 32'd4);
                chk({e.name, ".redirect"}, {31'd0, redirect}, {31'd0, e.redir});
                chk({e.name, ".addr_err"}, {31'd0, addr_err}, {31'd0, e.aerr});
                chk({e.name, ".exc_pending"}, {31'd0, exc_pending}, {31'd0, e.pend});
                if (e.chk_cnt) begin
                    chk({e.name, ".cnt_taken"}, {24'd0, cnt_taken}, {24'd0, e.tk});
                    chk({e.name, ".cnt_jump"}, {24'd0, cnt_jump}, {24'd0, e.jp});
                    chk({e.name, ".cnt_stall"}, {24'd0, cnt_stall}, {24'd0, e.st});
                end
            end
        end
    end

    function automatic exp_t mk(input string name, input logic [31:0] p, input logic r,
                                input logic a, input logic pd, input bit cc,
                                input logic [7:0] tk, input logic [7:0] jp, input logic [7:0] st);
        exp_t e;
        e.name = name; e.pc = p; e.redir = r; e.aerr = a; e.pend = pd; e.chk_cnt = cc;
        e.tk = PERF ? tk : 8'd0;
        e.jp = PERF ? jp : 8'd0;
        e.st = PERF ? st : 8'd0;
        return e;
    endfunction

    task automatic set_in(input logic v, input logic [3:0] op, input logic [31:0] p4,
                          input logic [31:0] rs, input logic [31:0] rt, input logic [15:0] imm,
                          input logic [25:0] idx, input logic st, input logic ex);
        id_valid = v; id_op = op; id_pc4 = p4; id_rs_val = rs; id_rt_val = rt;
        id_imm16 = imm; id_index = idx; stall = st; exc_req = ex;
    endtask

    task automatic step(input exp_t e);
        q.push_back(e);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic now_check(input exp_t e);
        q.push_back(e);
        -> chk_ev;
        #2;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        @(negedge clk);
        now_check(mk("reset", 32'h3000, 0, 0, 0, 1, 0, 0, 0));
        reset = 1'b0;

        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
        step(mk("seq1", 32'h3004, 0, 0, 0, 0, 0, 0, 0));
        step(mk("seq2", 32'h3008, 0, 0, 0, 0, 0, 0, 0));
        step(mk("seq3", 32'h300C, 0, 0, 0, 0, 0, 0, 0));

        set_in(1, 1, 32'h3008, 5, 5, 16'hFFFE, 0, 0, 0);
        step(mk("beq_t", 32'h3000, 1, 0, 0, 0, 0, 0, 0));
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
        step(mk("seq_after", 32'h3004, 0, 0, 0, 0, 0, 0, 0));
        set_in(1, 1, 32'h3008, 5, 6, 16'hFFFE, 0, 0, 0);
        step(mk("beq_nt", 32'h3008, 0, 0, 0, 0, 0, 0, 0));

        set_in(1, 4, 32'h3010, 32'h8000_0000, 0, 16'h0004, 0, 0, 0);
        step(mk("bltz_t", 32'h3020, 1, 0, 0, 0, 0, 0, 0));
        set_in(1, 6, 32'h3010, 0, 0, 16'h0004, 0, 0, 0);
        step(mk("bgtz_nt", 32'h3024, 0, 0, 0, 0, 0, 0, 0));
        set_in(1, 5, 32'h3028, 0, 0, 16'h0001, 0, 0, 0);
        step(mk("blez_t", 32'h302C, 1, 0, 0, 0, 0, 0, 0));
        set_in(1, 3, 32'h3010, 32'hFFFF_FFFF, 0, 16'h0004, 0, 0, 0);
        step(mk("bgez_nt", 32'h3030, 0, 0, 0, 0, 0, 0, 0));
        set_in(1, 2, 32'h3040, 1, 2, 16'h0010, 0, 0, 0);
        step(mk("bne_t", 32'h3080, 1, 0, 0, 0, 0, 0, 0));

        set_in(1, 8, 0, 32'h0000_3102, 0, 0, 0, 0, 0);
        step(mk("jr_misal", 32'h4180, 1, 1, 0, 0, 0, 0, 0));
        set_in(1, 7, 32'h3010, 0, 0, 0, 26'h0000C40, 0, 0);
        step(mk("jal", 32'h3100, 1, 0, 0, 0, 0, 0, 0));
        set_in(1, 8, 0, 32'h0000_3200, 0, 0, 0, 0, 0);
        step(mk("jr_ok", 32'h3200, 1, 0, 0, 0, 0, 0, 0));
        set_in(0, 1, 32'h3008, 5, 5, 16'hFFFE, 0, 0, 0);
        step(mk("invalid", 32'h3204, 0, 0, 0, 0, 0, 0, 0));
        set_in(1, 9, 32'h3008, 5, 5, 16'hFFFE, 0, 0, 0);
        step(mk("op9_seq", 32'h3208, 0, 0, 0, 0, 0, 0, 0));

        set_in(1, 1, 32'h3008, 5, 5, 16'hFFFE, 0, 0, 1);
        step(mk("exc_vs_br", 32'h4180, 1, 0, 0, 0, 0, 0, 0));
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
        step(mk("seq_exc", 32'h4184, 0, 0, 0, 0, 0, 0, 0));

        set_in(1, 1, 32'h3008, 5, 5, 16'hFFFE, 0, 1, 0);
        step(mk("stall_br", 32'h4184, 0, 0, 0, 0, 0, 0, 0));
        set_in(0, 0, 0, 0, 0, 0, 0, 1, 1);
        step(mk("stall_exc", 32'h4184, 0, 0, 1, 0, 0, 0, 0));
        set_in(0, 0, 0, 0, 0, 0, 0, 1, 0);
        step(mk("pend_hold", 32'h4184, 0, 0, 1, 0, 0, 0, 0));
        set_in(0, 0, 0, 0, 0, 0, 0, 1, 1);
        step(mk("pend_abs", 32'h4184, 0, 0, 1, 0, 0, 0, 0));
        set_in(1, 7, 32'h3010, 0, 0, 0, 26'h0000C40, 0, 0);
        step(mk("pend_apply", 32'h4180, 1, 0, 0, 0, 0, 0, 0));
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
        step(mk("no_queue", 32'h4184, 0, 0, 0, 0, 0, 0, 0));

        set_in(0, 0, 0, 0, 0, 0, 0, 1, 1);
        step(mk("pend_again", 32'h4184, 0, 0, 1, 0, 0, 0, 0));
        #1 reset = 1'b1;
        now_check(mk("rst_async", 32'h3000, 0, 0, 0, 1, 0, 0, 0));
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;

        set_in(1, 1, 32'h3008, 5, 5, 16'hFFFE, 0, 0, 0);
        step(mk("perf_beq1", 32'h3000, 1, 0, 0, 1, 1, 0, 0));
        step(mk("perf_beq2", 32'h3000, 1, 0, 0, 1, 2, 0, 0));
        set_in(1, 7, 32'h3010, 0, 0, 0, 26'h0000C40, 0, 0);
        step(mk("perf_j", 32'h3100, 1, 0, 0, 1, 2, 1, 0));
        set_in(0, 0, 0, 0, 0, 0, 0, 1, 0);
        step(mk("perf_st1", 32'h3100, 0, 0, 0, 1, 2, 1, 1));
        step(mk("perf_st2", 32'h3100, 0, 0, 0, 1, 2, 1, 2));
        step(mk("perf_st3", 32'h3100, 0, 0, 0, 1, 2, 1, 3));
        for (int i = 0; i < 256; i++) begin
            logic [7:0] st_exp;
            st_exp = 8'(3 + i + 1);
            step(mk("perf_wrap", 32'h3100, 0, 0, 0, 1, 2, 1, st_exp));
        end
        stall = 1'b0;
        drv_done = 1'b1;
    end

    initial begin
        int budget;
        budget = 0;
        while (!drv_done && budget < 2000) begin
            @(posedge clk);
            budget++;
        end
        if (!drv_done) begin
            bad++;
            $display("FAIL timeout: driver not done after %0d cycles", budget);
        end
        repeat (3) @(posedge clk);
        #2;
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL leftover: %0d expectations unchecked, required 0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
